booth_multiplier_seq: RTL

Sequential radix-2 Booth multiplier producing a signed 32-bit product from two signed 16-bit operands in 16 iterations. It sits directly upstream of the ALU's 16-bit ripple adder-subtractor: each iteration it drives that unit's A, B and add/subtract select, then consumes its 16-bit sum and overflow flag. The block owns all sequencing, partial-product registers and the start/done handshake.

---
 rtl/booth_multiplier_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, 16x16 signed -> 32-bit signed product.
// One iteration per cycle through an external 16-bit adder-subtractor.
module booth_multiplier_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] multiplicand,
  input  logic signed [15:0] multiplier,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] product,
  output logic        [15:0] add_a,
  output logic        [15:0] add_b,
  output logic               add_sel,
  input  logic        [15:0] add_sum,
  input  logic               add_ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic signed [15:0] acc;
  logic signed [15:0] m_reg;
  logic        [15:0] q_reg;
  logic               q_1;
  logic        [3:0]  cnt;

  logic        [15:0] new_hi;
  logic               shift_in;
  logic               do_op;
  logic               last;

  // Sign of the exact 17-bit partial sum; the adder's overflow flag recovers
  // the bit lost to its 16-bit width so 0x8000 operands stay exact.
  function automatic logic ext_sign(input logic [15:0] sum, input logic ovf,
                                    input logic [15:0] hold, input logic op);
    return op ? (sum[15] ^ ovf) : hold[15];
  endfunction

  assign add_a   = acc;
  assign add_b   = m_reg;
  assign add_sel = q_reg[0] & ~q_1;
  assign busy    = (state == RUN);

  always_comb begin
    do_op    = q_reg[0] ^ q_1;
    new_hi   = do_op ? add_sum : acc;
    shift_in = ext_sign(add_sum, add_ovf, acc, do_op);
    last     = (cnt == 4'd15);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      m_reg   <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            acc   <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          // Arithmetic shift right of {acc, q_reg, q_1} with the true sign.
          acc   <= {shift_in, new_hi[15:1]};
          q_reg <= {new_hi[0], q_reg[15:1]};
          q_1   <= q_reg[0];
          cnt   <= cnt + 4'd1;
          if (last) begin
            product <= {shift_in, new_hi, q_reg[15:1]};
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
